// File: rtl/spi_bit_counter_if.sv
// Control/status bundle between the SPI control FSM and the bit counter.
// Optional mark/mark_hit signals exist only when SPI_CNT_MARK_EN is defined.
interface spi_bit_counter_if #(
    parameter int WIDTH   = 5,
    parameter int FRAME_W = 8
);
    logic               clear;
    logic               start;
    logic               enable;
    logic [WIDTH-1:0]   len;
    logic               wrap_mode;
    logic [WIDTH-1:0]   count;
    logic               busy;
    logic               term_flag;
    logic               done;
    logic [FRAME_W-1:0] frames;
`ifdef SPI_CNT_MARK_EN
    logic [WIDTH-1:0]   mark;
    logic               mark_hit;

    modport master (
        output clear, start, enable, len, wrap_mode, mark,
        input  count, busy, term_flag, done, frames, mark_hit
    );

    modport slave (
        input  clear, start, enable, len, wrap_mode, mark,
        output count, busy, term_flag, done, frames, mark_hit
    );
`else
    modport master (
        output clear, start, enable, len, wrap_mode,
        input  count, busy, term_flag, done, frames
    );

    modport slave (
        input  clear, start, enable, len, wrap_mode,
        output count, busy, term_flag, done, frames
    );
`endif
endinterface

// File: rtl/spi_bit_counter.sv
// Programmable SPI frame/bit counter: one-shot (stop in HOLD) or auto-reload.
// Optional boundary marker output enabled by defining SPI_CNT_MARK_EN.
module spi_bit_counter #(
    parameter int WIDTH   = 5,
    parameter int FRAME_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    spi_bit_counter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   len_q, len_d;
    logic               wrap_q, wrap_d;
    logic               busy_q, term_q;
    logic               done_q, done_d;
    logic [FRAME_W-1:0] frames_q, frames_d;
    logic [WIDTH-1:0]   last_bit;
    logic               accept_start;
`ifdef SPI_CNT_MARK_EN
    logic               mark_hit_q, mark_hit_d;
`endif

    assign last_bit     = len_q - WIDTH'(1);
    // A zero-length start is meaningless and is dropped; start never interrupts a frame.
    assign accept_start = bus.start && (bus.len != '0) && (state_q != COUNT);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        wrap_d   = wrap_q;
        done_d   = 1'b0;
        frames_d = frames_q;
        if (bus.clear) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept_start) begin
                        len_d   = bus.len;
                        wrap_d  = bus.wrap_mode;
                        count_d = '0;
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    if (bus.enable) begin
                        if (count_q == last_bit) begin
                            done_d   = 1'b1;
                            frames_d = frames_q + FRAME_W'(1);
                            if (wrap_q) begin
                                count_d = '0;
                            end else begin
                                count_d = len_q;
                                state_d = HOLD;
                            end
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

`ifdef SPI_CNT_MARK_EN
    // Pulse only when count is (re)loaded or stepped, so idle/held values never retrigger.
    always_comb begin
        mark_hit_d = 1'b0;
        if (!bus.clear && (accept_start || (state_q == COUNT && bus.enable)))
            mark_hit_d = (count_d == bus.mark);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            len_q      <= '0;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
            term_q     <= 1'b0;
            done_q     <= 1'b0;
            frames_q   <= '0;
`ifdef SPI_CNT_MARK_EN
            mark_hit_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            wrap_q     <= wrap_d;
            busy_q     <= (state_d == COUNT);
            term_q     <= (state_d == HOLD);
            done_q     <= done_d;
            frames_q   <= frames_d;
`ifdef SPI_CNT_MARK_EN
            mark_hit_q <= mark_hit_d;
`endif
        end
    end

    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.term_flag = term_q;
    assign bus.done      = done_q;
    assign bus.frames    = frames_q;
`ifdef SPI_CNT_MARK_EN
    assign bus.mark_hit  = mark_hit_q;
`endif

endmodule

// File: tb/tb_spi_bit_counter.sv
// Scoreboard bench for spi_bit_counter; a second instance with FRAME_W=2 covers frame wrap.
// Mark checks are included when SPI_CNT_MARK_EN is defined.
module tb_spi_bit_counter;

    logic clk;
    logic reset;

    spi_bit_counter_if #(.WIDTH(5), .FRAME_W(8)) bus_a ();
    spi_bit_counter_if #(.WIDTH(5), .FRAME_W(2)) bus_b ();

    spi_bit_counter #(.WIDTH(5), .FRAME_W(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    spi_bit_counter #(.WIDTH(5), .FRAME_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    cnt;
        bit    bsy;
        bit    trm;
        bit    dn;
        int    fr;
        int    fr_b;
        bit    mh;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   exp_fr_b = 0;
    bit   exp_mh   = 1'b0;
    int   fr = 0;
    int   fb [5] = '{1, 2, 3, 0, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int cnt, input bit bsy, input bit trm,
                        input bit dn, input int f);
        exp_t e;
        e.tag  = tag;
        e.cnt  = cnt;
        e.bsy  = bsy;
        e.trm  = trm;
        e.dn   = dn;
        e.fr   = f;
        e.fr_b = exp_fr_b;
        e.mh   = exp_mh;
        sb.push_back(e);
    endtask

    task automatic compare_pending();
        exp_t e;
        check("sb_depth", 32'(sb.size()), 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".count"}, 32'(bus_a.count), 32'(e.cnt));
            check({e.tag, ".busy"},  32'(bus_a.busy),  32'(e.bsy));
            check({e.tag, ".term"},  32'(bus_a.term_flag), 32'(e.trm));
            check({e.tag, ".done"},  32'(bus_a.done),  32'(e.dn));
            check({e.tag, ".frames"}, 32'(bus_a.frames), 32'(e.fr));
            check({e.tag, ".frames_b"}, 32'(bus_b.frames), 32'(e.fr_b));
`ifdef SPI_CNT_MARK_EN
            check({e.tag, ".mark_hit"}, 32'(bus_a.mark_hit), 32'(e.mh));
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_pending();
    endtask

    task automatic set_a(input bit clr, input bit st, input bit en, input int ln, input bit wm);
        bus_a.clear     = clr;
        bus_a.start     = st;
        bus_a.enable    = en;
        bus_a.len       = 5'(ln);
        bus_a.wrap_mode = wm;
    endtask

    task automatic set_b(input bit st, input bit en, input int ln, input bit wm);
        bus_b.clear     = 1'b0;
        bus_b.start     = st;
        bus_b.enable    = en;
        bus_b.len       = 5'(ln);
        bus_b.wrap_mode = wm;
    endtask

    initial begin
        reset = 1'b0;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0);
`ifdef SPI_CNT_MARK_EN
        bus_a.mark = 5'd31;
        bus_b.mark = 5'd31;
`endif
        repeat (2) @(posedge clk);
        #1;
        push("reset", 0, 0, 0, 0, 0);
        compare_pending();
        reset = 1'b1;

        // Reset mid-frame
        set_a(0, 1, 0, 8, 0);
        push("t1_start", 0, 1, 0, 0, 0);
        tick();
        set_a(0, 0, 1, 8, 0);
        for (int i = 1; i <= 3; i++) begin
            push("t1_en", i, 1, 0, 0, 0);
            tick();
        end
        #2 reset = 1'b0;
        #1;
        push("t1_async_rst", 0, 0, 0, 0, 0);
        compare_pending();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push("t1_after_rst", 0, 0, 0, 0, 0);
            tick();
        end

        // One-shot, len=8
        set_a(0, 1, 0, 8, 0);
        push("t2_start", 0, 1, 0, 0, fr);
        tick();
        set_a(0, 0, 1, 8, 0);
        for (int i = 1; i <= 8; i++) begin
            push("t2_en", i, i < 8, i == 8, i == 8, (i == 8) ? 1 : 0);
            tick();
        end
        fr = 1;
        for (int i = 0; i < 3; i++) begin
            push("t2_hold", 8, 0, 1, 0, fr);
            tick();
        end

        // Wrap, len=4, started from HOLD with enable high
        set_a(0, 1, 1, 4, 1);
        push("t3_reload", 0, 1, 0, 0, fr);
        tick();
        set_a(0, 0, 1, 4, 1);
        for (int i = 1; i <= 12; i++) begin
            if (i % 4 == 0) fr++;
            push("t3_wrap", i % 4, 1, 0, i % 4 == 0, fr);
            tick();
        end

        // clear beats start
        set_a(1, 1, 1, 4, 1);
        push("t4_clear_start", 0, 0, 0, 0, fr);
        tick();
        set_a(0, 1, 1, 0, 1);
        push("t4_len0", 0, 0, 0, 0, fr);
        tick();
        // start during COUNT is ignored; len_q stays 8
        set_a(0, 1, 0, 8, 0);
        push("t4_start8", 0, 1, 0, 0, fr);
        tick();
        set_a(0, 0, 1, 8, 0);
        for (int i = 1; i <= 2; i++) begin
            push("t4_en", i, 1, 0, 0, fr);
            tick();
        end
        set_a(0, 1, 0, 3, 1);
        push("t4_start_in_count", 2, 1, 0, 0, fr);
        tick();
        set_a(0, 0, 1, 3, 1);
        for (int i = 3; i <= 8; i++) begin
            push("t4_cont", i, i < 8, i == 8, i == 8, fr + ((i == 8) ? 1 : 0));
            tick();
        end
        fr++;
        set_a(0, 1, 0, 0, 0);
        push("t4_hold_len0", 8, 0, 1, 0, fr);
        tick();
        // len=1 wrap: done every enabled cycle
        set_a(0, 1, 1, 1, 1);
        push("t4_len1_start", 0, 1, 0, 0, fr);
        tick();
        set_a(0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            fr++;
            push("t4_len1", 0, 1, 0, 1, fr);
            tick();
        end
        set_a(1, 0, 0, 1, 1);
        push("t4_clear", 0, 0, 0, 0, fr);
        tick();
        set_a(0, 0, 0, 0, 0);

`ifdef SPI_CNT_MARK_EN
        bus_a.mark = 5'd8;
        set_a(0, 1, 0, 16, 0);
        push("t6_start", 0, 1, 0, 0, fr);
        tick();
        set_a(0, 0, 1, 16, 0);
        for (int i = 1; i <= 16; i++) begin
            exp_mh = (i == 8);
            push("t6_mark8", i, i < 16, i == 16, i == 16, fr + ((i == 16) ? 1 : 0));
            exp_mh = 1'b0;
            tick();
        end
        fr++;
        bus_a.mark = 5'd20;
        set_a(0, 1, 0, 16, 0);
        push("t6_restart", 0, 1, 0, 0, fr);
        tick();
        set_a(0, 0, 1, 16, 0);
        for (int i = 1; i <= 16; i++) begin
            push("t6_mark20", i, i < 16, i == 16, i == 16, fr + ((i == 16) ? 1 : 0));
            tick();
        end
        fr++;
        bus_a.mark = 5'd31;
        set_a(1, 0, 0, 0, 0);
        push("t6_clear", 0, 0, 0, 0, fr);
        tick();
        set_a(0, 0, 0, 0, 0);
`endif

        // frames wrap on the FRAME_W=2 instance
        set_b(1, 0, 1, 1);
        push("t5_start", 0, 0, 0, 0, fr);
        tick();
        set_b(0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            exp_fr_b = fb[i];
            push("t5_frames_wrap", 0, 0, 0, 0, fr);
            tick();
        end
        set_b(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
